// File: rtl/ps2_pkg.sv
// Shared types and cycle-count helpers for the PS/2 host-side blocks.
// Cycle counts are derived from the clock frequency and a duration in microseconds.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_CLK,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_TIMEOUT
  } ps2_tx_state_t;

  function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                               input int unsigned us);
    return (freq_hz / 1_000_000) * us;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pin, plus a registered falling-edge strobe.
// Flops reset to 1 (the idle level of an open-drain line) so reset never fakes an edge.
module ps2_line_sync (
  input  logic clk,
  input  logic reset_i,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic fall_q;

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fall_q <= prev_q & ~sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts start/data/parity/stop out on device clock edges and checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned FREQ_HZ           = 25_000_000,
  parameter int unsigned INHIBIT_US        = 100,
  parameter int unsigned START_TIMEOUT_US  = 15000,
  parameter int unsigned PACKET_TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       timeout_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int unsigned US_CYCLES      = us_to_cycles(FREQ_HZ, 1);
  localparam int unsigned INHIBIT_CYCLES = us_to_cycles(FREQ_HZ, INHIBIT_US);
  localparam int unsigned START_CYCLES   = us_to_cycles(FREQ_HZ, START_TIMEOUT_US);
  localparam int unsigned PACKET_CYCLES  = us_to_cycles(FREQ_HZ, PACKET_TIMEOUT_US);
  // Sized for the longer of the two timeouts so either can be loaded.
  localparam int unsigned TIMER_MAX      = max_u(START_CYCLES, PACKET_CYCLES);
  localparam int          TW             = $clog2(TIMER_MAX + 1);

  localparam logic [TW-1:0] INHIBIT_LOAD = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] REQ_LOAD     = TW'(US_CYCLES - 1);
  localparam logic [TW-1:0] START_LOAD   = TW'(START_CYCLES - 1);
  localparam logic [TW-1:0] PACKET_LOAD  = TW'(PACKET_CYCLES - 1);

  ps2_tx_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [9:0]    frame_q, frame_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic          ack_bad_q, ack_bad_d;

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk     (clk),
    .reset_i (reset_i),
    .pin_i   (ps2_clk_i),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk     (clk),
    .reset_i (reset_i),
    .pin_i   (ps2_data_i),
    .level_o (data_level),
    .fall_o  (data_fall_unused)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    ack_bad_d = ack_bad_q;

    unique case (state_q)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid_i) begin
          // Frame LSB first: data, odd parity, then a 1 that releases the line as stop.
          frame_d   = {1'b1, ~^tx_data_i, tx_data_i};
          bit_idx_d = 4'd0;
          ack_bad_d = 1'b0;
          timer_d   = INHIBIT_LOAD;
          clk_oe_d  = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        if (timer_q == '0) begin
          data_oe_d = 1'b1;
          timer_d   = REQ_LOAD;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b1;
        if (timer_q == '0) begin
          clk_oe_d = 1'b0;
          timer_d  = START_LOAD;
          state_d  = ST_WAIT_CLK;
        end
      end
      ST_WAIT_CLK: begin
        data_oe_d = 1'b1;
        if (clk_fall) begin
          data_oe_d = ~frame_q[0];
          frame_d   = {1'b0, frame_q[9:1]};
          bit_idx_d = 4'd1;
          timer_d   = PACKET_LOAD;
          state_d   = ST_SEND;
        end else if (timer_q == '0) begin
          data_oe_d = 1'b0;
          state_d   = ST_TIMEOUT;
        end
      end
      ST_SEND: begin
        if (clk_fall) begin
          data_oe_d = ~frame_q[0];
          frame_d   = {1'b0, frame_q[9:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) begin
            state_d = ST_ACK;
          end
        end else if (timer_q == '0) begin
          data_oe_d = 1'b0;
          state_d   = ST_TIMEOUT;
        end
      end
      ST_ACK: begin
        data_oe_d = 1'b0;
        if (clk_fall) begin
          ack_bad_d = data_level;
          state_d   = ST_WAIT_IDLE;
        end else if (timer_q == '0) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_WAIT_IDLE: begin
        data_oe_d = 1'b0;
        // Hold here for the pulse cycle so ready only returns afterwards.
        if (done_q) begin
          state_d = ST_IDLE;
        end else if (clk_level && data_level) begin
          done_d    = 1'b1;
          ack_err_d = ack_bad_q;
        end
      end
      ST_TIMEOUT: begin
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 4'd0;
      frame_q   <= 10'd0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      ack_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      ack_bad_q <= ack_bad_d;
    end
  end

  assign tx_ready_o    = (state_q == ST_IDLE);
  assign busy_o        = ~tx_ready_o;
  assign done_o        = done_q;
  assign ack_err_o     = ack_err_q;
  assign timeout_o     = (state_q == ST_TIMEOUT);
  assign ps2_clk_oe_o  = clk_oe_q;
  assign ps2_data_oe_o = data_oe_q;

endmodule
